regfile_sb: RTL and testbench
=============================

# regfile_sb

- General-purpose register file with a pending-write scoreboard.
- Sits at the consumer end of the write-destination select path: it receives the destination index (rd, rt, or constant 31 for JAL) and the write-back data, and serves the decode stage.
- Provides two combinational read ports and one synchronous write port.
- Tracks which registers have an issued but not yet written-back producer, and raises a stall when decode reads one of them.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREG, 32, register count; index width is fixed at 5 bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rs_addr  in  5  read port A index
- rt_addr  in  5  read port B index
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- rs_busy  out  1  port A register has a pending write
- rt_busy  out  1  port B register has a pending write
- stall  out  1  rs_busy | rt_busy
- iss_valid  in  1  an instruction writing iss_dst is issued this cycle
- iss_dst  in  5  destination index of the issued instruction
- wb_en  in  1  write-back strobe
- wb_addr  in  5  write-back destination (output of the JAL destination select)
- wb_data  in  DATA_W  write-back value
- pend_cnt  out  6  number of busy bits set (0..31)

## Operation
- Storage: NREG x DATA_W array.
  - Register 0 reads as 0 at all times.
  - Writes to index 0 are discarded.
- Write:
  - On a rising clk edge with wb_en=1 and wb_addr!=0, write wb_data to array[wb_addr].
- Read:
  - rs_data and rt_data are combinational from the array; index 0 forces 0.
- Scoreboard: busy[31:1] register vector; busy[0] is hardwired to 0.
  - On a clk edge, when wb_en=1 and wb_addr!=0, clear busy[wb_addr].
  - On a clk edge, when iss_valid=1 and iss_dst!=0, set busy[iss_dst].
  - Same index set and cleared in one cycle: set wins. The new producer is in flight; the old write still updates the array.
  - iss_valid with iss_dst=0 has no effect.
- Busy outputs:
  - rs_busy = busy[rs_addr], and rt_busy = busy[rt_addr], each subject to the bypass rule in Configuration.
  - stall is the OR of the two.
- pend_cnt: registered population count of busy.
  - It is updated on the same edge as busy, so it always equals popcount(busy) in the same cycle.
  - It cannot overflow: at most 31 bits can be set.
- The block does not gate iss_valid with stall. Upstream must not assert iss_valid while stall=1.

## Timing
- Reset (asynchronous, immediate, independent of clk):
  - All array entries, busy and pend_cnt go to 0.
  - Hence rs_data=rt_data=0, rs_busy=rt_busy=stall=0 during and after reset.
- Reset asserted mid-operation discards any write or issue on that edge. The first post-reset edge behaves as from an empty state.
- Write latency:
  - Data written at edge N is visible on the read ports from edge N onward, i.e. in cycle N+1 without bypass.
  - With bypass it is visible in the same cycle as wb_en.
- Scoreboard latency:
  - iss_valid at cycle N makes busy visible from cycle N+1.
  - wb_en at cycle N clears busy from cycle N+1, or in cycle N under bypass.
- Read paths are combinational: port outputs settle within the cycle of an address change. There is no read latency.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-through forwarding. When wb_en=1, wb_addr!=0 and wb_addr==rs_addr, then rs_data=wb_data and rs_busy=0 in the same cycle. The same applies to the rt port.
  - Exception: if busy is also being re-set for that index this cycle (iss_valid with the same iss_dst), data forwards but busy still follows the current busy bit, because the set has not yet taken effect.
- REGFILE_BYPASS_EN undefined:
  - No forwarding; reads and busy come only from registered state.
  - A consumer of a write-back register stalls one extra cycle.

## Test plan
- Reset then read all 32 indices -> every rs_data/rt_data = 0, stall=0, pend_cnt=0.
- wb_en, wb_addr=0, wb_data=0xDEADBEEF; then read index 0 -> 0. Then wb_addr=31, wb_data=0x00400008 (JAL return address); read rt_addr=31 next cycle -> 0x00400008.
- iss_valid, iss_dst=5; next cycle rs_addr=5 -> rs_busy=1, stall=1, pend_cnt=1. Then wb_en, wb_addr=5, wb_data=7:
  - bypass on -> rs_data=7, stall=0 in the same cycle;
  - bypass off -> stall=0, rs_data=7 next cycle.
- Same cycle iss_valid, iss_dst=9 and wb_en, wb_addr=9, wb_data=0x11 with busy[9]=1 -> next cycle busy[9]=1, array[9]=0x11, pend_cnt unchanged.
- Issue dst 1..31 on consecutive cycles -> pend_cnt reaches 31. iss_dst=0 -> pend_cnt stays 31.
- With busy[3]=1 and array[3]=0x55, assert rst asynchronously between edges -> outputs 0 immediately. After release, read index 3 -> data 0, busy 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle between the decode/write-back side and the register file.
//
// Handshake: there is no valid/ready pairing on this bus. iss_valid and wb_en
// are single-cycle strobes that take effect on the next rising clk edge. The
// file never back-pressures them. stall is advisory: the master must not
// raise iss_valid while stall=1.
//
// Signals:
//   rs_addr, rt_addr   read indices                   (master -> slave)
//   rs_data, rt_data   combinational read data        (slave -> master)
//   rs_busy, rt_busy   pending-write flags per port   (slave -> master)
//   stall              rs_busy | rt_busy              (slave -> master)
//   iss_valid, iss_dst issue of a producer            (master -> slave)
//   wb_en, wb_addr,
//   wb_data            write-back port                (master -> slave)
//   pend_cnt           number of pending producers    (slave -> master)
//
// Modports: master (decode / write-back side), slave (regfile_sb).
interface regfile_sb_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              stall;
  logic              iss_valid;
  logic [4:0]        iss_dst;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [5:0]        pend_cnt;

  modport master (
    output rs_addr, rt_addr, iss_valid, iss_dst, wb_en, wb_addr, wb_data,
    input  rs_data, rt_data, rs_busy, rt_busy, stall, pend_cnt
  );

  modport slave (
    input  rs_addr, rt_addr, iss_valid, iss_dst, wb_en, wb_addr, wb_data,
    output rs_data, rt_data, rs_busy, rt_busy, stall, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with a pending-write scoreboard.
//
// Two combinational read ports, one synchronous write port. A busy bit per
// register marks an issued producer whose result has not been written back.
// Decode sees rs_busy/rt_busy/stall for the registers it is reading.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset (clears array, busy and pend_cnt)
//   bus   regfile_sb_if.slave (read ports, issue port, write-back port,
//         busy/stall flags, pend_cnt)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-back data and busy clear are forwarded to the read
//                ports in the same cycle as wb_en.
//   undefined -> reads and busy come only from registered state.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [5:0]        pend_cnt_q;
  logic              wb_ok;
  logic              iss_ok;

  // Index 0 is the hardwired zero register; indices at or beyond NREG do
  // not exist and behave like it.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (int'({27'd0, idx}) < NREG);
  endfunction

  function automatic logic [5:0] popcount(input logic [NREG-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  assign wb_ok  = bus.wb_en && idx_ok(bus.wb_addr);
  assign iss_ok = bus.iss_valid && idx_ok(bus.iss_dst);

  // Clear for the write-back first, then set for the issue, so a producer
  // issued on the same edge as the old write-back stays pending.
  always_comb begin
    busy_nxt = busy;
    if (wb_ok)  busy_nxt[bus.wb_addr] = 1'b0;
    if (iss_ok) busy_nxt[bus.iss_dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      busy       <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
      busy       <= busy_nxt;
      pend_cnt_q <= popcount(busy_nxt);
    end
  end

  // Registered-state view of each read port.
  logic [DATA_W-1:0] rs_mem;
  logic [DATA_W-1:0] rt_mem;
  logic              rs_busy_q;
  logic              rt_busy_q;

  always_comb begin
    rs_mem    = '0;
    rt_mem    = '0;
    rs_busy_q = 1'b0;
    rt_busy_q = 1'b0;
    if (idx_ok(bus.rs_addr)) begin
      rs_mem    = mem[bus.rs_addr];
      rs_busy_q = busy[bus.rs_addr];
    end
    if (idx_ok(bus.rt_addr)) begin
      rt_mem    = mem[bus.rt_addr];
      rt_busy_q = busy[bus.rt_addr];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic rs_hit;
  logic rt_hit;
  logic rs_reiss;
  logic rt_reiss;

  assign rs_hit   = wb_ok && (bus.wb_addr == bus.rs_addr);
  assign rt_hit   = wb_ok && (bus.wb_addr == bus.rt_addr);
  // A same-cycle re-issue of the forwarded index keeps the current busy bit:
  // the new producer's set is not visible until the next edge.
  assign rs_reiss = iss_ok && (bus.iss_dst == bus.rs_addr);
  assign rt_reiss = iss_ok && (bus.iss_dst == bus.rt_addr);

  always_comb begin
    bus.rs_data = rs_hit ? bus.wb_data : rs_mem;
    bus.rt_data = rt_hit ? bus.wb_data : rt_mem;
    bus.rs_busy = (rs_hit && !rs_reiss) ? 1'b0 : rs_busy_q;
    bus.rt_busy = (rt_hit && !rt_reiss) ? 1'b0 : rt_busy_q;
  end
`else
  always_comb begin
    bus.rs_data = rs_mem;
    bus.rt_data = rt_mem;
    bus.rs_busy = rs_busy_q;
    bus.rt_busy = rt_busy_q;
  end
`endif

  assign bus.stall    = bus.rs_busy | bus.rt_busy;
  assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed-vector bench for regfile_sb.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_regfile_sb;

  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];

  regfile_sb_if #(.DATA_W(DATA_W)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_dst   = 5'd0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    #2;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_pend",  32'(bus.pend_cnt), 32'd0);
    repeat (2) tick();
    #2 rst = 1'b0;
    tick();

    // Every index reads 0 after reset.
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      check("init_rs", bus.rs_data, 32'd0);
      check("init_rt", bus.rt_data, 32'd0);
      check("init_stall", 32'(bus.stall), 32'd0);
    end
    check("init_pend", 32'(bus.pend_cnt), 32'd0);
    tick();

    // Write to r0 is discarded; JAL link write to r31.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hDEADBEEF;
    tick();
    idle();
    bus.rs_addr = 5'd0;
    #1 check("r0_read", bus.rs_data, 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 32'h00400008;
    tick();
    idle();
    bus.rt_addr = 5'd31;
    #1 check("r31_read", bus.rt_data, 32'h00400008);
    check("r31_busy", 32'(bus.rt_busy), 32'd0);

    // Issue r5, then write it back.
    tick();
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd5;
    tick();
    idle();
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd0;
    #1;
    check("r5_busy",  32'(bus.rs_busy), 32'd1);
    check("r5_stall", 32'(bus.stall), 32'd1);
    check("r5_pend",  32'(bus.pend_cnt), 32'd1);
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r5_wb_data_same",  bus.rs_data, 32'd7);
    check("r5_wb_stall_same", 32'(bus.stall), 32'd0);
`else
    check("r5_wb_data_same",  bus.rs_data, 32'd0);
    check("r5_wb_stall_same", 32'(bus.stall), 32'd1);
`endif
    tick();
    idle();
    #1;
    check("r5_data_next",  bus.rs_data, 32'd7);
    check("r5_stall_next", 32'(bus.stall), 32'd0);
    check("r5_pend_next",  32'(bus.pend_cnt), 32'd0);

    // Same-cycle set and clear of r9 while busy: set wins, data still lands.
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd9;
    tick();
    idle();
    check("r9_pend_pre", 32'(bus.pend_cnt), 32'd1);
    bus.rs_addr = 5'd9;
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd9;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h11;
    #1;
    check("r9_busy_same", 32'(bus.rs_busy), 32'd1);
`ifdef REGFILE_BYPASS_EN
    check("r9_data_same", bus.rs_data, 32'h11);
`else
    check("r9_data_same", bus.rs_data, 32'd0);
`endif
    tick();
    idle();
    #1;
    check("r9_busy_next", 32'(bus.rs_busy), 32'd1);
    check("r9_data_next", bus.rs_data, 32'h11);
    check("r9_pend_next", 32'(bus.pend_cnt), 32'd1);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h11;
    tick();
    idle();
    check("r9_pend_clr", 32'(bus.pend_cnt), 32'd0);

    // Fill the scoreboard: pend_cnt walks 1..31, then r0 issue is ignored.
    for (int d = 1; d <= 31; d++) exp_q.push_back(32'(d));
    for (int d = 1; d <= 31; d++) begin
      bus.iss_valid = 1'b1; bus.iss_dst = 5'(d);
      tick();
      check("fill_pend", 32'(bus.pend_cnt), exp_q.pop_front());
    end
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd0;
    tick();
    idle();
    check("fill_pend_r0", 32'(bus.pend_cnt), 32'd31);
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd31;
    #1;
    check("fill_r0_busy",  32'(bus.rs_busy), 32'd0);
    check("fill_r31_busy", 32'(bus.rt_busy), 32'd1);

    // r3 busy with data 0x55, then asynchronous reset between edges.
    tick();
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd3;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h55;
    tick();
    idle();
    bus.rs_addr = 5'd3; bus.rt_addr = 5'd3;
    #1;
    check("r3_data", bus.rs_data, 32'h55);
    check("r3_busy", 32'(bus.rs_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_data",  bus.rs_data, 32'd0);
    check("arst_busy",  32'(bus.rs_busy), 32'd0);
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_pend",  32'(bus.pend_cnt), 32'd0);
    // Write and issue attempted while reset is held are discarded.
    bus.iss_valid = 1'b1; bus.iss_dst = 5'd3;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h99;
    tick();
    idle();
    #2 rst = 1'b0;
    tick();
    #1;
    check("post_rst_data", bus.rs_data, 32'd0);
    check("post_rst_busy", 32'(bus.rs_busy), 32'd0);
    check("post_rst_pend", 32'(bus.pend_cnt), 32'd0);
    check("post_rst_r31",  bus.rt_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
